mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 41 ++++
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arb_timer.sv | 35 +++
 rtl/mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the fetch/data memory arbiter.
package mem_arb_pkg;

   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_MAX_DM_STREAK  = 4;
   localparam int DEF_TIMEOUT_CYCLES = 255;

   // Instruction fetches always read the whole word.
   localparam logic [3:0] FETCH_BE = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   // Fields forwarded to the memory for one access.
   typedef struct packed {
      logic                      we;
      logic [3:0]                be;
      logic [DEF_DATA_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] wdata;
   } req_t;

   // A fetch is a plain full-word read with no write data.
   function automatic req_t fetch_bundle(input logic [DEF_DATA_WIDTH-1:0] addr);
      req_t r;
      r       = '0;
      r.we    = 1'b0;
      r.be    = FETCH_BE;
      r.addr  = addr;
      r.wdata = {DEF_DATA_WIDTH{1'b0}};
      return r;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core requesters, the arbiter and the memory model.
interface mem_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  if_req;
   logic [DATA_WIDTH-1:0] if_addr;
   logic [DATA_WIDTH-1:0] if_rdata;
   logic                  if_ready;

   logic                  dm_req;
   logic                  dm_we;
   logic [3:0]            dm_be;
   logic [DATA_WIDTH-1:0] dm_addr;
   logic [DATA_WIDTH-1:0] dm_wdata;
   logic [DATA_WIDTH-1:0] dm_rdata;
   logic                  dm_ready;

   logic                  mem_req;
   logic                  mem_we;
   logic [3:0]            mem_be;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_rvalid;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic                  stall;
   logic                  err;

   // Arbiter view.
   modport slave (
      input  if_req, if_addr,
      input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      input  mem_rvalid, mem_rdata,
      output if_rdata, if_ready,
      output dm_rdata, dm_ready,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output stall, err
   );

   // Requester and memory side view.
   modport master (
      output if_req, if_addr,
      output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      output mem_rvalid, mem_rdata,
      input  if_rdata, if_ready,
      input  dm_rdata, dm_ready,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  stall, err
   );
endinterface

// File: rtl/mem_arb_timer.sv
// WAIT-state watchdog: counts cycles without a memory response and flags
// the last allowed cycle.
module mem_arb_timer
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] count_r;

   // Cycle counter: cleared when an access is issued, advanced while waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (en) begin
         count_r <= count_r + TW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign expire = (count_r == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// memory stage. Each access runs IDLE -> ISSUE -> WAIT; data wins ties unless
// it has already won MAX_DM_STREAK times in a row while a fetch was waiting.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int MAX_DM_STREAK  = DEF_MAX_DM_STREAK,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   localparam int            SW         = $clog2(MAX_DM_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

   state_t                state_r;
   state_t                state_next_s;
   owner_t                owner_r;
   logic [SW-1:0]         streak_r;
   logic [SW-1:0]         streak_next_s;
   req_t                  mem_fields_r;
   logic                  err_r;

   logic                  grant_dm_s;
   logic                  grant_if_s;
   logic                  mem_req_s;
   logic                  timer_clr_s;
   logic                  timer_en_s;
   logic                  timer_expire_s;
   logic                  timeout_s;
   logic                  if_ready_s;
   logic                  dm_ready_s;
   logic [DATA_WIDTH-1:0] if_rdata_s;
   logic [DATA_WIDTH-1:0] dm_rdata_s;

   mem_arb_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (timer_clr_s),
      .en     (timer_en_s),
      .expire (timer_expire_s)
   );

   // Arbitration and next streak value, evaluated only while idle.
   always_comb begin
      grant_dm_s    = 1'b0;
      grant_if_s    = 1'b0;
      streak_next_s = streak_r;
      if (state_r == IDLE) begin
         if (bus.dm_req && !(bus.if_req && (streak_r == STREAK_MAX))) begin
            grant_dm_s = 1'b1;
            if (bus.if_req) begin
               if (streak_r != STREAK_MAX) begin
                  streak_next_s = streak_r + SW'(1);
               end else begin
                  streak_next_s = streak_r;
               end
            end else begin
               streak_next_s = '0;
            end
         end else if (bus.if_req) begin
            grant_if_s    = 1'b1;
            streak_next_s = '0;
         end else begin
            grant_dm_s    = 1'b0;
            grant_if_s    = 1'b0;
         end
      end else begin
         streak_next_s = streak_r;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.if_req || bus.dm_req) begin
               state_next_s = ISSUE;
            end else begin
               state_next_s = IDLE;
            end
         end
         ISSUE: begin
            state_next_s = WAIT;
         end
         WAIT: begin
            if (bus.mem_rvalid || timer_expire_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = WAIT;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Outputs: issue strobe, timer control, and completion routed to the owner.
   always_comb begin
      mem_req_s   = 1'b0;
      timer_clr_s = 1'b0;
      timer_en_s  = 1'b0;
      timeout_s   = 1'b0;
      if_ready_s  = 1'b0;
      dm_ready_s  = 1'b0;
      if_rdata_s  = {DATA_WIDTH{1'b0}};
      dm_rdata_s  = {DATA_WIDTH{1'b0}};
      case (state_r)
         IDLE: begin
            mem_req_s = 1'b0;
         end
         ISSUE: begin
            mem_req_s   = 1'b1;
            timer_clr_s = 1'b1;
         end
         WAIT: begin
            if (bus.mem_rvalid) begin
               if (owner_r == OWN_DM) begin
                  dm_ready_s = 1'b1;
                  dm_rdata_s = bus.mem_rdata;
               end else begin
                  if_ready_s = 1'b1;
                  if_rdata_s = bus.mem_rdata;
               end
            end else if (timer_expire_s) begin
               // Abort: the owner is released with zero data.
               timeout_s = 1'b1;
               if (owner_r == OWN_DM) begin
                  dm_ready_s = 1'b1;
               end else begin
                  if_ready_s = 1'b1;
               end
            end else begin
               timer_en_s = 1'b1;
            end
         end
         default: begin
            mem_req_s = 1'b0;
         end
      endcase
   end

   // Latch the winner, its fields and the updated streak on a grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_r      <= OWN_IF;
         streak_r     <= '0;
         mem_fields_r <= '0;
      end else if (grant_dm_s) begin
         owner_r      <= OWN_DM;
         streak_r     <= streak_next_s;
         mem_fields_r <= '{we: bus.dm_we, be: bus.dm_be,
                           addr: bus.dm_addr, wdata: bus.dm_wdata};
      end else if (grant_if_s) begin
         owner_r      <= OWN_IF;
         streak_r     <= streak_next_s;
         mem_fields_r <= fetch_bundle(bus.if_addr);
      end else begin
         owner_r      <= owner_r;
         streak_r     <= streak_r;
         mem_fields_r <= mem_fields_r;
      end
   end

   // Sticky timeout flag; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (timeout_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign bus.mem_req   = mem_req_s;
   assign bus.mem_we    = mem_fields_r.we;
   assign bus.mem_be    = mem_fields_r.be;
   assign bus.mem_addr  = mem_fields_r.addr;
   assign bus.mem_wdata = mem_fields_r.wdata;
   assign bus.if_ready  = if_ready_s;
   assign bus.if_rdata  = if_rdata_s;
   assign bus.dm_ready  = dm_ready_s;
   assign bus.dm_rdata  = dm_rdata_s;
   assign bus.err       = err_r;
   assign bus.stall     = (bus.if_req & ~if_ready_s) | (bus.dm_req & ~dm_ready_s);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester agents fed from command queues, a
// one-cycle memory model, and a scoreboard of expected read data per port.
module tb_mem_arbiter;

   typedef struct {
      bit          is_dm;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   mem_en = 1'b1;
   bit   stray  = 1'b0;
   int   errors = 0;
   int   checks = 0;
   bit   if_active = 1'b0;
   bit   dm_active = 1'b0;

   vec_t        if_cmds[$];
   vec_t        dm_cmds[$];
   logic [31:0] exp_if_q[$];
   logic [31:0] exp_dm_q[$];
   bit          log_q[$];
   vec_t        vecs[6];

   mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

   mem_arbiter #(
      .DATA_WIDTH     (32),
      .MAX_DM_STREAK  (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      case (a)
         32'h0000_0010: return 32'h0050_0093;
         32'h0000_0100: return 32'hDEAD_BEEF;
         default:       return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   function automatic vec_t mk(input bit is_dm, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata);
      vec_t v;
      v.is_dm = is_dm; v.we = we; v.be = be;
      v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
      return v;
   endfunction

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #2;
         if (if_cmds.size() == 0 && dm_cmds.size() == 0 && exp_if_q.size() == 0 &&
             exp_dm_q.size() == 0 && !bus.if_req && !bus.dm_req) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: queues not drained, got pending work expected none", name);
      end
   endtask

   // Fetch agent: holds a request until if_ready, then drops or renews it.
   initial begin
      bit   done;
      vec_t v;
      bus.if_req = 1'b0; bus.if_addr = '0;
      forever begin
         @(negedge clk); done = bus.if_ready;
         @(posedge clk); #1;
         if (done) begin bus.if_req = 1'b0; if_active = 1'b0; end
         if (!if_active && if_cmds.size() > 0) begin
            v = if_cmds.pop_front();
            bus.if_addr = v.addr; bus.if_req = 1'b1;
            exp_if_q.push_back(v.exp_rdata);
            if_active = 1'b1;
         end
      end
   end

   // Data agent: same handshake for loads and stores.
   initial begin
      bit   done;
      vec_t v;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
      forever begin
         @(negedge clk); done = bus.dm_ready;
         @(posedge clk); #1;
         if (done) begin bus.dm_req = 1'b0; dm_active = 1'b0; end
         if (!dm_active && dm_cmds.size() > 0) begin
            v = dm_cmds.pop_front();
            bus.dm_we = v.we; bus.dm_be = v.be; bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
            bus.dm_req = 1'b1;
            exp_dm_q.push_back(v.exp_rdata);
            dm_active = 1'b1;
         end
      end
   end

   // Memory model: answers one cycle after mem_req; can inject a stray rvalid.
   initial begin
      bit          pend, pwe, take_stray;
      logic [31:0] paddr;
      bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         pend = bus.mem_req && mem_en && !rst;
         pwe = bus.mem_we; paddr = bus.mem_addr;
         take_stray = stray; stray = 1'b0;
         @(posedge clk); #1;
         if (pend) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = pwe ? 32'h0 : mem_model(paddr);
         end else if (take_stray) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
         end else begin
            bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
         end
      end
   end

   // Monitor/scoreboard: every cycle check stall, and pop on each ready.
   initial begin
      logic exp_stall;
      forever begin
         @(negedge clk);
         exp_stall = (bus.if_req & ~bus.if_ready) | (bus.dm_req & ~bus.dm_ready);
         check("stall", bus.stall, exp_stall);
         check("ready_onehot", bus.if_ready & bus.dm_ready, 1'b0);
         if (bus.if_ready) begin
            log_q.push_back(1'b0);
            check("dm_rdata_idle_port", bus.dm_rdata, 32'h0);
            if (exp_if_q.size() == 0) check("if_ready_unexpected", 1'b1, 1'b0);
            else check("if_rdata", bus.if_rdata, exp_if_q.pop_front());
         end
         if (bus.dm_ready) begin
            log_q.push_back(1'b1);
            check("if_rdata_idle_port", bus.if_rdata, 32'h0);
            if (exp_dm_q.size() == 0) check("dm_ready_unexpected", 1'b1, 1'b0);
            else check("dm_rdata", bus.dm_rdata, exp_dm_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit exp_log[11];
      exp_log = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[0] = mk(1'b0, 1'b0, 4'b1111, 32'h0000_0044, 32'h0, 32'h5A5A_0044);
      vecs[1] = mk(1'b1, 1'b0, 4'b1111, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
      vecs[2] = mk(1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'h1234_5678, 32'h0);
      vecs[3] = mk(1'b0, 1'b0, 4'b1111, 32'h0000_1000, 32'h0, 32'h5A5A_1000);
      vecs[4] = mk(1'b1, 1'b0, 4'b1111, 32'h0000_0300, 32'h0, 32'h5A5A_0300);
      vecs[5] = mk(1'b1, 1'b1, 4'b1100, 32'h0000_0204, 32'hCAFE_F00D, 32'h0);

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_if_ready", bus.if_ready, 1'b0);
      check("rst_dm_ready", bus.dm_ready, 1'b0);
      check("rst_if_rdata", bus.if_rdata, 32'h0);
      check("rst_dm_rdata", bus.dm_rdata, 32'h0);
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_mem_be", bus.mem_be, 4'h0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
      check("rst_err", bus.err, 1'b0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);

      // Single fetch, cycle by cycle.
      if_cmds.push_back(mk(1'b0, 1'b0, 4'b1111, 32'h0000_0010, 32'h0, 32'h0050_0093));
      @(negedge clk); check("f_c0_stall", bus.stall, 1'b1); check("f_c0_mem_req", bus.mem_req, 1'b0);
      @(negedge clk); check("f_c1_mem_req", bus.mem_req, 1'b1); check("f_c1_addr", bus.mem_addr, 32'h10);
      check("f_c1_stall", bus.stall, 1'b1);
      @(negedge clk); check("f_c2_if_ready", bus.if_ready, 1'b1);
      check("f_c2_if_rdata", bus.if_rdata, 32'h0050_0093); check("f_c2_stall", bus.stall, 1'b0);
      wait_idle("single_fetch");

      // Table of isolated accesses: issue fields at cycle 1, ready at cycle 2.
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].is_dm) dm_cmds.push_back(vecs[i]);
         else if_cmds.push_back(vecs[i]);
         @(negedge clk); check("vec_c0_mem_req", bus.mem_req, 1'b0);
         @(negedge clk);
         check("vec_c1_mem_req", bus.mem_req, 1'b1);
         check("vec_c1_mem_addr", bus.mem_addr, vecs[i].addr);
         check("vec_c1_mem_we", bus.mem_we, vecs[i].we);
         if (vecs[i].is_dm) begin
            check("vec_c1_mem_be", bus.mem_be, vecs[i].be);
            check("vec_c1_mem_wdata", bus.mem_wdata, vecs[i].wdata);
         end
         @(negedge clk);
         check("vec_c2_dm_ready", bus.dm_ready, vecs[i].is_dm);
         check("vec_c2_if_ready", bus.if_ready, !vecs[i].is_dm);
         wait_idle("vector");
      end

      // Simultaneous requests: data first, fetch issued in cycle 4.
      dm_cmds.push_back(mk(1'b1, 1'b0, 4'b1111, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF));
      if_cmds.push_back(mk(1'b0, 1'b0, 4'b1111, 32'h0000_0010, 32'h0, 32'h0050_0093));
      @(negedge clk);
      @(negedge clk); check("sim_c1_addr", bus.mem_addr, 32'h100);
      @(negedge clk); check("sim_c2_dm_ready", bus.dm_ready, 1'b1); check("sim_c2_if_ready", bus.if_ready, 1'b0);
      check("sim_c2_dm_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
      @(negedge clk); check("sim_c3_mem_req", bus.mem_req, 1'b0);
      @(negedge clk); check("sim_c4_mem_req", bus.mem_req, 1'b1); check("sim_c4_addr", bus.mem_addr, 32'h10);
      @(negedge clk); check("sim_c5_if_ready", bus.if_ready, 1'b1);
      wait_idle("simultaneous");

      // Starvation limit: two fetches against a stream of nine loads.
      log_q.delete();
      if_cmds.push_back(mk(1'b0, 1'b0, 4'b1111, 32'h0000_0080, 32'h0, mem_model(32'h80)));
      if_cmds.push_back(mk(1'b0, 1'b0, 4'b1111, 32'h0000_0084, 32'h0, mem_model(32'h84)));
      for (int i = 0; i < 9; i++) begin
         dm_cmds.push_back(mk(1'b1, 1'b0, 4'b1111, 32'h400 + 32'(4 * i), 32'h0, mem_model(32'h400 + 32'(4 * i))));
      end
      wait_idle("starvation");
      check("starve_count", log_q.size(), 11);
      for (int i = 0; i < 11 && i < log_q.size(); i++) begin
         check("starve_order", log_q[i], exp_log[i]);
      end

      // Timeout: silent memory, abort on the 8th WAIT cycle, err sticks.
      mem_en = 1'b0;
      dm_cmds.push_back(mk(1'b1, 1'b0, 4'b1111, 32'h0000_0600, 32'h0, 32'h0));
      @(negedge clk);
      @(negedge clk); check("to_c1_mem_req", bus.mem_req, 1'b1);
      repeat (6) @(negedge clk);
      @(negedge clk); check("to_c8_dm_ready", bus.dm_ready, 1'b0); check("to_c8_err", bus.err, 1'b0);
      @(negedge clk); check("to_c9_dm_ready", bus.dm_ready, 1'b1); check("to_c9_err", bus.err, 1'b0);
      @(negedge clk); check("to_c10_err", bus.err, 1'b1);
      wait_idle("timeout");
      #1 stray = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("stray_dm_ready", bus.dm_ready, 1'b0); check("stray_if_ready", bus.if_ready, 1'b0);
      check("stray_err", bus.err, 1'b1);

      // Reset during WAIT abandons the access; the held request is re-served.
      if_cmds.push_back(mk(1'b0, 1'b0, 4'b1111, 32'h0000_0020, 32'h0, 32'h5A5A_0020));
      @(negedge clk);
      @(negedge clk); check("rw_c1_mem_req", bus.mem_req, 1'b1);
      @(negedge clk);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk); check("rw_c3_if_ready", bus.if_ready, 1'b0);
      @(posedge clk); #1; rst = 1'b0; mem_en = 1'b1;
      @(negedge clk); check("rw_c4_mem_req", bus.mem_req, 1'b0); check("rw_c4_err", bus.err, 1'b0);
      check("rw_c4_if_ready", bus.if_ready, 1'b0); check("rw_c4_mem_addr", bus.mem_addr, 32'h0);
      @(negedge clk); check("rw_c5_mem_req", bus.mem_req, 1'b1); check("rw_c5_addr", bus.mem_addr, 32'h20);
      @(negedge clk); check("rw_c6_if_ready", bus.if_ready, 1'b1);
      wait_idle("reset_mid_wait");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
